// File: rtl/proj_slot_scheduler.sv
// Shared pool of on-screen projectile slots: arbitrates boss/player spawn requests,
// moves live shots on each step tick and retires them at the screen edges or on hit.
module proj_slot_scheduler #(
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned PROJ_H   = 8,
  parameter int unsigned STEP     = 4
) (
  input  logic        clk,
  input  logic        sw,
  input  logic        step_pulse,
  input  logic        boss_req,
  input  logic [9:0]  boss_x,
  input  logic [8:0]  boss_y,
  input  logic        player_req,
  input  logic [9:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic [4:0]  hit_clr,
  output logic        boss_gnt,
  output logic        player_gnt,
  output logic [4:0]  slot_valid,
  output logic [4:0]  slot_owner,
  output logic [49:0] slot_x,
  output logic [44:0] slot_y,
  output logic        full,
  output logic [7:0]  drops
);

  localparam int unsigned N_SLOTS = 5;
  localparam int unsigned XW      = 10;
  localparam int unsigned YW      = 9;
  localparam int unsigned YEW     = YW + 1;
  localparam int unsigned IW      = 3;
  localparam int unsigned DW      = 8;

  localparam logic [YEW-1:0] Y_LIMIT = YEW'(SCREEN_H - PROJ_H);
  localparam logic [YEW-1:0] STEP_YE = YEW'(STEP);
  localparam logic [YW-1:0]  STEP_Y  = YW'(STEP);

  logic               pend_boss_q, pend_boss_d;
  logic               pend_player_q, pend_player_d;
  logic               rr_q, rr_d;                 // 0 = boss preferred, 1 = player preferred
  logic [XW-1:0]      boss_x_q, boss_x_d, player_x_q, player_x_d;
  logic [YW-1:0]      boss_y_q, boss_y_d, player_y_q, player_y_d;
  logic [N_SLOTS-1:0] valid_q, valid_d, owner_q, owner_d;
  logic [XW-1:0]      x_q [N_SLOTS];
  logic [XW-1:0]      x_d [N_SLOTS];
  logic [YW-1:0]      y_q [N_SLOTS];
  logic [YW-1:0]      y_d [N_SLOTS];
  logic               boss_gnt_q, boss_gnt_d, player_gnt_q, player_gnt_d;
  logic [DW-1:0]      drops_q, drops_d;

  logic               free_found;
  logic [IW-1:0]      free_idx;
  logic               win_boss, win_player;
  logic               drop_boss, drop_player;
  logic [DW:0]        drop_sum;

  // Lowest free slot, judged on registered valid so slots freed this edge wait a cycle
  always_comb begin
    free_found = 1'b0;
    free_idx   = IW'(0);
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    pend_boss_d   = pend_boss_q;
    pend_player_d = pend_player_q;
    rr_d          = rr_q;
    boss_x_d      = boss_x_q;
    boss_y_d      = boss_y_q;
    player_x_d    = player_x_q;
    player_y_d    = player_y_q;
    valid_d       = valid_q;
    owner_d       = owner_q;
    x_d           = x_q;
    y_d           = y_q;

    win_boss   = free_found && pend_boss_q && (!pend_player_q || !rr_q);
    win_player = free_found && pend_player_q && (!pend_boss_q || rr_q);
    if (free_found && pend_boss_q && pend_player_q) begin
      rr_d = ~rr_q;
    end

    if (win_boss)   pend_boss_d   = 1'b0;
    if (win_player) pend_player_d = 1'b0;

    // A request arriving while its requester is still pending is lost
    drop_boss   = boss_req && pend_boss_q;
    drop_player = player_req && pend_player_q;
    if (boss_req && !pend_boss_q) begin
      pend_boss_d = 1'b1;
      boss_x_d    = boss_x;
      boss_y_d    = boss_y;
    end
    if (player_req && !pend_player_q) begin
      pend_player_d = 1'b1;
      player_x_d    = player_x;
      player_y_d    = player_y;
    end
    drop_sum = {1'b0, drops_q} + (DW+1)'(drop_boss) + (DW+1)'(drop_player);
    drops_d  = drop_sum[DW] ? '1 : drop_sum[DW-1:0];

    // Hit retire beats movement; boss shots fall, player shots rise
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (valid_q[i]) begin
        if (hit_clr[i]) begin
          valid_d[i] = 1'b0;
        end else if (step_pulse) begin
          if (!owner_q[i]) begin
            if (({1'b0, y_q[i]} + STEP_YE) > Y_LIMIT) valid_d[i] = 1'b0;
            else                                     y_d[i]     = y_q[i] + STEP_Y;
          end else begin
            if (y_q[i] < STEP_Y) valid_d[i] = 1'b0;
            else                 y_d[i]     = y_q[i] - STEP_Y;
          end
        end
      end
    end

    if (win_boss || win_player) begin
      valid_d[free_idx] = 1'b1;
      owner_d[free_idx] = win_player;
      x_d[free_idx]     = win_player ? player_x_q : boss_x_q;
      y_d[free_idx]     = win_player ? player_y_q : boss_y_q;
    end

    boss_gnt_d   = win_boss;
    player_gnt_d = win_player;
  end

  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      pend_boss_q   <= 1'b0;
      pend_player_q <= 1'b0;
      rr_q          <= 1'b0;
      boss_x_q      <= '0;
      boss_y_q      <= '0;
      player_x_q    <= '0;
      player_y_q    <= '0;
      valid_q       <= '0;
      owner_q       <= '0;
      boss_gnt_q    <= 1'b0;
      player_gnt_q  <= 1'b0;
      drops_q       <= '0;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      pend_boss_q   <= pend_boss_d;
      pend_player_q <= pend_player_d;
      rr_q          <= rr_d;
      boss_x_q      <= boss_x_d;
      boss_y_q      <= boss_y_d;
      player_x_q    <= player_x_d;
      player_y_q    <= player_y_d;
      valid_q       <= valid_d;
      owner_q       <= owner_d;
      boss_gnt_q    <= boss_gnt_d;
      player_gnt_q  <= player_gnt_d;
      drops_q       <= drops_d;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  always_comb begin
    slot_x = '0;
    slot_y = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      slot_x[XW*i +: XW] = x_q[i];
      slot_y[YW*i +: YW] = y_q[i];
    end
  end

  assign boss_gnt   = boss_gnt_q;
  assign player_gnt = player_gnt_q;
  assign slot_valid = valid_q;
  assign slot_owner = owner_q;
  assign full       = &valid_q;
  assign drops      = drops_q;

endmodule
